// File: rtl/qmult_rr_scheduler_pkg.sv
// Shared types for the round-robin qmult scheduler: FSM state encoding and tag-width helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package qmult_rr_scheduler_pkg;

    // IDLE: waiting for a request; MUL: product settling on captured operands;
    // RESP: result held on the response port until the consumer takes it.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Requester tag width; never below 1 so the tag ports always exist.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/qmult_rr_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first active request after ptr, wrapping around.
// Latency: purely combinational.
// Backpressure: en low suppresses every grant; ptr is owned and updated by the caller.
//
// Ports:
//   req       per-requester request vector
//   ptr       index of the last winner; the search starts at ptr+1
//   en        grant enable
//   grant     one-hot grant (all zero when nothing is granted)
//   grant_idx index of the winner (0 when nothing is granted)
//   grant_any high when a grant is issued
module qmult_rr_scheduler_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_any
);

    always_comb begin
        int             pos;
        logic [IDW-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        pos       = 0;
        idx       = '0;
        // Offsets 1..NREQ: the previous winner is examined last, giving it lowest priority.
        for (int k = 1; k <= NREQ; k++) begin
            pos = (int'(ptr) + k) % NREQ;
            idx = IDW'(pos);
            if (en && !grant_any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                grant_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/qmult_rr_scheduler.sv
// Shares one sign-magnitude fixed-point multiplier among NREQ requesters with round-robin arbitration.
// Latency: 2 cycles from the grant edge to resp_valid; up to 1 op every 2 cycles.
// Backpressure: resp_ready low holds the result stable and withholds every req_ready.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   req_valid / req_ready            per-requester handshake; at most one req_ready bit is high
//   req_multiplicand/req_multiplier  packed operands, requester i at [i*N +: N]
//   resp_valid / resp_ready          result handshake
//   resp_result, resp_ovr, resp_id   sign-magnitude product, magnitude overflow, owning requester
//   busy                             high whenever the scheduler is not idle
module qmult_rr_scheduler
    import qmult_rr_scheduler_pkg::*;
#(
    parameter  int N    = 32,
    parameter  int Q    = 15,
    parameter  int NREQ = 4,
    localparam int IDW  = idx_width(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_multiplicand,
    input  logic [NREQ*N-1:0] req_multiplier,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [N-1:0]      resp_result,
    output logic              resp_ovr,
    output logic [IDW-1:0]    resp_id,
    output logic              busy
);

    localparam int PW = 2 * N - 2;  // full product width of two (N-1)-bit magnitudes

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  op_id;
    logic [N-1:0]    op_a;
    logic [N-1:0]    op_b;

    logic            grant_en;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            grant_any;
    logic [N-1:0]    sel_a;
    logic [N-1:0]    sel_b;

    logic [PW-1:0]   prod;
    logic [N-2:0]    prod_mag;
    logic            prod_sign;
    logic            prod_ovr;
    logic            unused_prod_lsbs;

    // A new operand pair can only be accepted when the result slot is free
    // or is being drained in this very cycle.
    assign grant_en = (state == ST_IDLE) || ((state == ST_RESP) && resp_ready);

    qmult_rr_scheduler_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .en        (grant_en),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign req_ready = grant;
    assign busy      = (state != ST_IDLE);

    // One-hot operand select driven by the grant vector.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a = req_multiplicand[i*N +: N];
                sel_b = req_multiplier[i*N +: N];
            end
        end
    end

    // Magnitude multiply with truncation of the Q low fraction bits; any set bit
    // above the kept window means the magnitude does not fit in N-1 bits.
    // A negative zero (sign set, magnitude zero) is passed through as is.
    assign prod             = PW'(op_a[N-2:0]) * PW'(op_b[N-2:0]);
    assign prod_mag         = prod[N-2+Q:Q];
    assign prod_ovr         = |prod[PW-1:N-1+Q];
    assign prod_sign        = op_a[N-1] ^ op_b[N-1];
    assign unused_prod_lsbs = ^prod[Q-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rr_ptr      <= IDW'(NREQ - 1);
            op_a        <= '0;
            op_b        <= '0;
            op_id       <= '0;
            resp_valid  <= 1'b0;
            resp_result <= '0;
            resp_ovr    <= 1'b0;
            resp_id     <= '0;
        end else begin
            // grant_any already implies IDLE, or RESP being drained.
            if (grant_any) begin
                op_a   <= sel_a;
                op_b   <= sel_b;
                op_id  <= grant_idx;
                rr_ptr <= grant_idx;
            end

            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        state <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    resp_result <= {prod_sign, prod_mag};
                    resp_ovr    <= prod_ovr;
                    resp_id     <= op_id;
                    resp_valid  <= 1'b1;
                    state       <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= grant_any ? ST_MUL : ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qmult_rr_scheduler.sv
// Bench for qmult_rr_scheduler: directed scenarios followed by randomized traffic.
// Expected values come from a transaction-level model (queue of pending products, round-robin pick).
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_qmult_rr_scheduler;

    localparam int N    = 32;
    localparam int Q    = 15;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    typedef struct {
        logic [N-1:0] res;
        logic         ovr;
        int           id;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_multiplicand;
    logic [NREQ*N-1:0] req_multiplier;
    logic              resp_valid;
    logic              resp_ready;
    logic [N-1:0]      resp_result;
    logic              resp_ovr;
    logic [IDW-1:0]    resp_id;
    logic              busy;

    always #5 clk = ~clk;

    qmult_rr_scheduler #(.N(N), .Q(Q), .NREQ(NREQ)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_multiplicand (req_multiplicand),
        .req_multiplier   (req_multiplier),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_result      (resp_result),
        .resp_ovr         (resp_ovr),
        .resp_id          (resp_id),
        .busy             (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Requester / consumer stimulus, applied to the DUT at the next step.
    logic [NREQ-1:0] drv_valid;
    logic [N-1:0]    drv_a [NREQ];
    logic [N-1:0]    drv_b [NREQ];
    logic            drv_rr;
    int              mode;      // 0: requester goes quiet after grant, 1: re-arms with new data, 2: caller decides

    // Reference model state.
    int   cyc;
    bit   outstanding;          // an operation granted and not yet taken by the consumer
    int   grant_cyc;
    int   ptr;                  // last granted requester
    exp_t exp_q [$];
    int   last_w;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] rand_op();
        logic [N-1:0] v;
        v        = $urandom;
        v[N-2:0] = v[N-2:0] >> $urandom_range(0, N - 2);
        return v;
    endfunction

    // Fixed-point product from plain integer arithmetic.
    function automatic exp_t model_mul(input logic [N-1:0] a, input logic [N-1:0] b, input int id);
        exp_t            e;
        longint unsigned ma, mb, p, sh;
        ma    = 64'(a[N-2:0]);
        mb    = 64'(b[N-2:0]);
        p     = ma * mb;
        sh    = p >> Q;
        e.res = {a[N-1] ^ b[N-1], sh[N-2:0]};
        e.ovr = (p >> (N - 1 + Q)) != 0;
        e.id  = id;
        return e;
    endfunction

    task automatic model_reset();
        outstanding = 1'b0;
        exp_q.delete();
        ptr = NREQ - 1;
    endtask

    // One clock cycle: apply stimulus, check outputs against the model, advance the model.
    task automatic step();
        logic            exp_rv;
        logic [NREQ-1:0] exp_ready;
        int              w;
        int              i;
        @(posedge clk);
        #1;
        cyc++;
        req_valid  = drv_valid;
        resp_ready = drv_rr;
        for (int k = 0; k < NREQ; k++) begin
            req_multiplicand[k*N +: N] = drv_a[k];
            req_multiplier[k*N +: N]   = drv_b[k];
        end
        @(negedge clk);
        exp_rv = outstanding && (cyc - grant_cyc >= 2);
        chk("resp_valid", 64'(resp_valid), 64'(exp_rv));
        chk("busy", 64'(busy), 64'(outstanding));
        if (exp_rv && exp_q.size() > 0) begin
            chk("resp_result", 64'(resp_result), 64'(exp_q[0].res));
            chk("resp_ovr", 64'(resp_ovr), 64'(exp_q[0].ovr));
            chk("resp_id", 64'(resp_id), 64'(exp_q[0].id));
        end
        w = -1;
        if (!outstanding || (exp_rv && drv_rr)) begin
            for (int k = 1; k <= NREQ; k++) begin
                i = (ptr + k) % NREQ;
                if (w < 0 && drv_valid[i]) w = i;
            end
        end
        exp_ready = '0;
        if (w >= 0) exp_ready[w] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        if (exp_rv && drv_rr) begin
            void'(exp_q.pop_front());
            outstanding = 1'b0;
        end
        if (w >= 0) begin
            exp_q.push_back(model_mul(drv_a[w], drv_b[w], w));
            outstanding = 1'b1;
            grant_cyc   = cyc;
            ptr         = w;
            if (mode == 0) begin
                drv_valid[w] = 1'b0;
            end else if (mode == 1) begin
                drv_a[w] = rand_op();
                drv_b[w] = rand_op();
            end
        end
        last_w = w;
    endtask

    task automatic check_resp(input string tag, input logic [N-1:0] res, input logic ovr, input int id);
        chk({tag, "_vld"}, 64'(resp_valid), 64'(1));
        chk({tag, "_res"}, 64'(resp_result), 64'(res));
        chk({tag, "_ovr"}, 64'(resp_ovr), 64'(ovr));
        chk({tag, "_id"}, 64'(resp_id), 64'(id));
    endtask

    int           g_idx [8];
    int           g_cyc [8];
    int           ng;
    int           waited;
    logic [N-1:0] snap_res;
    logic [IDW-1:0] snap_id;

    initial begin
        rst_n            = 1'b0;
        req_valid        = '0;
        resp_ready       = 1'b0;
        req_multiplicand = '0;
        req_multiplier   = '0;
        drv_valid        = '0;
        drv_rr           = 1'b1;
        for (int k = 0; k < NREQ; k++) begin
            drv_a[k] = '0;
            drv_b[k] = '0;
        end
        mode      = 0;
        cyc       = 0;
        grant_cyc = 0;
        last_w    = -1;
        model_reset();

        // Reset state.
        #12;
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_resp_result", 64'(resp_result), 64'(0));
        chk("rst_resp_ovr", 64'(resp_ovr), 64'(0));
        chk("rst_resp_id", 64'(resp_id), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // 1.5 * 2.0 from requester 0, 2 cycles after grant.
        drv_valid = 4'b0001;
        drv_a[0]  = 32'h0000C000;
        drv_b[0]  = 32'h00010000;
        step();
        chk("t1_grant", 64'(req_ready), 64'(4'b0001));
        step();
        chk("t1_early", 64'(resp_valid), 64'(0));
        step();
        check_resp("t1", 32'h00018000, 1'b0, 0);
        step();

        // -1.0 * 0.5 from requester 2.
        drv_valid = 4'b0100;
        drv_a[2]  = 32'h80008000;
        drv_b[2]  = 32'h00004000;
        step();
        chk("t2_grant", 64'(req_ready), 64'(4'b0100));
        step();
        step();
        check_resp("t2", 32'h80004000, 1'b0, 2);
        step();

        // Overflow: magnitude wraps to zero with the flag set.
        drv_valid = 4'b0010;
        drv_a[1]  = 32'h40000000;
        drv_b[1]  = 32'h00010000;
        step();
        step();
        step();
        check_resp("t3", 32'h00000000, 1'b1, 1);
        step();

        // All four requesting continuously after a fresh reset.
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        mode  = 1;
        for (int k = 0; k < NREQ; k++) begin
            drv_a[k] = rand_op();
            drv_b[k] = rand_op();
        end
        drv_valid = 4'b1111;
        drv_rr    = 1'b1;
        ng        = 0;
        for (int s = 0; s < 10; s++) begin
            step();
            for (int k = 0; k < NREQ; k++) begin
                if (req_ready[k] && ng < 8) begin
                    g_idx[ng] = k;
                    g_cyc[ng] = cyc;
                    ng++;
                end
            end
        end
        chk("t4_count", 64'(ng), 64'(5));
        for (int k = 0; k < 5; k++) begin
            chk("t4_order", 64'(g_idx[k]), 64'(k % NREQ));
            if (k > 0) chk("t4_spacing", 64'(g_cyc[k] - g_cyc[k-1]), 64'(2));
        end

        // Consumer stalls for 5 cycles while a result is held.
        drv_rr = 1'b0;
        waited = 0;
        step();
        while (!resp_valid && waited < 4) begin
            step();
            waited++;
        end
        chk("t5_resp_seen", 64'(resp_valid), 64'(1));
        snap_res = resp_result;
        snap_id  = resp_id;
        for (int s = 0; s < 5; s++) begin
            step();
            chk("t5_no_ready", 64'(req_ready), 64'(0));
            chk("t5_hold_res", 64'(resp_result), 64'(snap_res));
            chk("t5_hold_id", 64'(resp_id), 64'(snap_id));
        end
        drv_rr = 1'b1;
        step();
        chk("t5_regrant", 64'($countones(req_ready)), 64'(1));

        // Reset during MUL drops the operation; requester 0 wins first afterwards.
        mode      = 0;
        drv_valid = '0;
        for (int s = 0; s < 3; s++) step();
        drv_valid = 4'b0100;
        drv_a[2]  = rand_op();
        drv_b[2]  = rand_op();
        step();
        step();
        rst_n     = 1'b0;
        req_valid = '0;
        #1;
        chk("t6_rst_vld", 64'(resp_valid), 64'(0));
        chk("t6_rst_busy", 64'(busy), 64'(0));
        model_reset();
        drv_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < NREQ; k++) begin
            drv_a[k] = rand_op();
            drv_b[k] = rand_op();
        end
        drv_valid = 4'b1111;
        step();
        chk("t6_first_grant", 64'(req_ready), 64'(4'b0001));
        drv_valid = '0;

        // Randomized traffic with random consumer backpressure and valid withdrawal.
        mode = 2;
        for (int s = 0; s < 3000; s++) begin
            drv_rr = ($urandom_range(0, 3) != 0);
            step();
            for (int k = 0; k < NREQ; k++) begin
                if (last_w == k) begin
                    drv_a[k]     = rand_op();
                    drv_b[k]     = rand_op();
                    drv_valid[k] = 1'($urandom_range(0, 1));
                end else if (drv_valid[k]) begin
                    if ($urandom_range(0, 7) == 0) drv_valid[k] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    drv_valid[k] = 1'b1;
                    drv_a[k]     = rand_op();
                    drv_b[k]     = rand_op();
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
